counter_pulse_source: RTL and testbench
=======================================

Name: counter_pulse_source

Overview:
- Plant-side source model for the involuntary counter-increment interface of the control-pulse generator.
- Accumulates +1/-1 plant pulses (CDU, PIPA, gyro style) into a signed backlog.
- Presents the backlog one increment at a time as PINC/MINC requests, or PCDU/MCDU requests in CDU mode.
- Holds each request until the AGC completes the counter cycle (INKL high then low). This is the requesting end of the counter interface.

Parameters:
- ACC_W, 8, width of signed backlog accumulator (two's complement).
- CDU_MODE, 0, 1 = drive PCDU/MCDU instead of PINC/MINC.
- TIMEOUT, 64, CLOCK cycles allowed in REQ without INKL before STALL is set.

Ports:
- CLOCK  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- UP_PULSE  in  1  one-cycle +1 plant pulse.
- DN_PULSE  in  1  one-cycle -1 plant pulse.
- INKL  in  1  AGC counter-increment cycle in progress.
- GOJAM  in  1  AGC restart; aborts the current request.
- PINC  out  1  plus-increment request (tied 0 when CDU_MODE=1).
- MINC  out  1  minus-increment request (tied 0 when CDU_MODE=1).
- PCDU  out  1  CDU plus request (tied 0 when CDU_MODE=0).
- MCDU  out  1  CDU minus request (tied 0 when CDU_MODE=0).
- BACKLOG  out  ACC_W  signed pending net increments.
- OVF  out  1  sticky: accumulator saturated.
- STALL  out  1  sticky: request timed out.

Behaviour:
- Reset (async, rst=1): state IDLE, all requests 0, BACKLOG=0, OVF=0, STALL=0, timeout counter 0.
- Accumulator update, each cycle: delta = UP_PULSE - DN_PULSE + svc, where svc is -1 if a plus request completes this cycle, +1 if a minus request completes, else 0.
  - UP and DN in the same cycle cancel.
  - Result saturates at +(2^(ACC_W-1)-1) and -(2^(ACC_W-1)). Any saturation sets OVF.
- States: IDLE, REQ, SERV, GAP.
- IDLE: if BACKLOG != 0, latch dir = sign(BACKLOG) and go to REQ. Requests are registered outputs, so the request asserts 1 cycle after BACKLOG becomes nonzero.
- REQ: assert the request line selected by dir and CDU_MODE. The timeout counter increments.
  - INKL=1: go to SERV and clear the timeout counter.
  - Counter reaches TIMEOUT-1 with INKL=0: set STALL and stay in REQ, request still held.
- SERV: request held while INKL=1. INKL falling (sampled 0): completion. Apply svc per latched dir, deassert request, go to GAP.
- GAP: one cycle with all requests low, then IDLE. This guarantees a visible request edge between consecutive increments.
- Direction latched at REQ entry is not changed by later pulses. If BACKLOG flips sign meanwhile, the completion still applies the latched svc.
- GOJAM=1 in any state: next state IDLE, requests drop next cycle, timeout counter cleared. BACKLOG, OVF and STALL are retained. A pulse arriving in the GOJAM cycle is still accumulated.
- INKL high while in IDLE or GAP is ignored.
- At most one increment is requested at a time; at most one completion per INKL pulse.

Optional Feature:
- Macro COUNTER_PULSE_SOURCE_COUNT_EN.
- Defined: adds output port SERVICED (16 bits), a wrapping count of completed increments. Reset 0. Increments on each completion; not cleared by GOJAM.
- Undefined: no SERVICED port; no extra logic.

Test Plan:
- Reset, then UP_PULSE for 3 cycles (CDU_MODE=0) → BACKLOG=3. PINC rises 1 cycle after BACKLOG=1. Drive INKL high 2 cycles, then low, three times → PINC drops after each INKL fall with a 1-cycle GAP low. BACKLOG steps 3,2,1,0. MINC stays 0 throughout.
- UP_PULSE and DN_PULSE together for 5 cycles → BACKLOG stays 0, no request. Then DN_PULSE ×2 → MINC asserted, BACKLOG=-2.
- CDU_MODE=1, UP_PULSE once → PCDU=1, PINC=0. INKL pulse → PCDU clears, BACKLOG=0.
- Request pending, INKL never raised, TIMEOUT=64 → STALL=1 at cycle 64 after REQ entry, PINC still high. A later INKL pulse completes normally; STALL stays 1.
- ACC_W=8, 130 UP_PULSE with no service → BACKLOG=127, OVF=1. rst mid-SERV → everything 0 immediately (async).
- GOJAM during SERV with BACKLOG=4 → request drops next cycle, BACKLOG stays 4, new REQ issued after re-entering IDLE. With COUNTER_PULSE_SOURCE_COUNT_EN defined, SERVICED does not increment for the aborted request.

Source files
------------

// File: rtl/counter_pulse_source.sv
// Plant-side requester for the counter-increment interface: accumulates +/-1 pulses, issues PINC/MINC (or PCDU/MCDU).
// Optional macro COUNTER_PULSE_SOURCE_COUNT_EN adds the 16-bit SERVICED completion counter.
module counter_pulse_source #(
  parameter int ACC_W    = 8,
  parameter int CDU_MODE = 0,
  parameter int TIMEOUT  = 64
) (
  input  logic             CLOCK,
  input  logic             rst,
  input  logic             UP_PULSE,
  input  logic             DN_PULSE,
  input  logic             INKL,
  input  logic             GOJAM,
  output logic             PINC,
  output logic             MINC,
  output logic             PCDU,
  output logic             MCDU,
  output logic [ACC_W-1:0] BACKLOG,
  output logic             OVF,
  output logic             STALL
`ifdef COUNTER_PULSE_SOURCE_COUNT_EN
  , output logic [15:0]    SERVICED
`endif
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic signed [ACC_W+1:0] ONE  = {{(ACC_W+1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W+1:0] MAXV = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W+1:0] MINV = {3'b111, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, REQ, SERV, GAP} state_t;

  state_t                   state, state_n;
  logic                     dir_plus, dir_plus_n;
  logic [TW-1:0]            tcnt, tcnt_n;
  logic                     stall_n;
  logic                     done;
  logic                     plus_q, minus_q, plus_n, minus_n;
  logic signed [ACC_W-1:0]  acc, acc_n;
  logic signed [ACC_W+1:0]  sum;
  logic                     sat;

  always_comb begin
    state_n    = state;
    dir_plus_n = dir_plus;
    tcnt_n     = tcnt;
    stall_n    = STALL;
    done       = 1'b0;
    if (GOJAM) begin
      state_n = IDLE;
      tcnt_n  = '0;
    end else begin
      case (state)
        IDLE: if (acc != '0) begin
          state_n    = REQ;
          dir_plus_n = ~acc[ACC_W-1];
          tcnt_n     = '0;
        end
        REQ: if (INKL) begin
          state_n = SERV;
          tcnt_n  = '0;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          stall_n = 1'b1;
        end else begin
          tcnt_n = tcnt + TW'(1);
        end
        SERV: if (!INKL) begin
          done    = 1'b1;
          state_n = GAP;
        end
        GAP: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
    // Requests are registered from the next state so they appear with the state change.
    plus_n  = ((state_n == REQ) || (state_n == SERV)) &&  dir_plus_n;
    minus_n = ((state_n == REQ) || (state_n == SERV)) && !dir_plus_n;
  end

  always_comb begin
    sum = {{2{acc[ACC_W-1]}}, acc};
    if (UP_PULSE) sum = sum + ONE;
    if (DN_PULSE) sum = sum - ONE;
    if (done)     sum = dir_plus ? (sum - ONE) : (sum + ONE);
    sat   = 1'b0;
    acc_n = sum[ACC_W-1:0];
    if (sum > MAXV) begin
      acc_n = MAXV[ACC_W-1:0];
      sat   = 1'b1;
    end else if (sum < MINV) begin
      acc_n = MINV[ACC_W-1:0];
      sat   = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      dir_plus <= 1'b0;
      tcnt     <= '0;
      plus_q   <= 1'b0;
      minus_q  <= 1'b0;
      acc      <= '0;
      OVF      <= 1'b0;
      STALL    <= 1'b0;
    end else begin
      state    <= state_n;
      dir_plus <= dir_plus_n;
      tcnt     <= tcnt_n;
      plus_q   <= plus_n;
      minus_q  <= minus_n;
      acc      <= acc_n;
      OVF      <= OVF | sat;
      STALL    <= stall_n;
    end
  end

`ifdef COUNTER_PULSE_SOURCE_COUNT_EN
  always_ff @(posedge CLOCK or posedge rst) begin
    if (rst)       SERVICED <= '0;
    else if (done) SERVICED <= SERVICED + 16'd1;
  end
`endif

  assign BACKLOG = acc;
  assign PINC    = (CDU_MODE == 0) && plus_q;
  assign MINC    = (CDU_MODE == 0) && minus_q;
  assign PCDU    = (CDU_MODE != 0) && plus_q;
  assign MCDU    = (CDU_MODE != 0) && minus_q;

endmodule

// File: tb/tb_counter_pulse_source.sv
// Scoreboard bench: two instances (normal and CDU mode) share stimulus and are checked against a transaction-level model.
module tb_counter_pulse_source;
  localparam int ACC_W   = 8;
  localparam int TIMEOUT = 64;
  localparam int BMAX    = (1 << (ACC_W - 1)) - 1;
  localparam int BMIN    = -(1 << (ACC_W - 1));

  logic CLOCK = 1'b0;
  logic rst, up, dn, inkl, gojam;
  logic pinc0, minc0, pcdu0, mcdu0, ovf0, stall0;
  logic pinc1, minc1, pcdu1, mcdu1, ovf1, stall1;
  logic [ACC_W-1:0] bl0, bl1;
`ifdef COUNTER_PULSE_SOURCE_COUNT_EN
  logic [15:0] srv0, srv1;
`endif

  always #5 CLOCK = ~CLOCK;

  counter_pulse_source #(.ACC_W(ACC_W), .CDU_MODE(0), .TIMEOUT(TIMEOUT)) dut0 (
    .CLOCK(CLOCK), .rst(rst), .UP_PULSE(up), .DN_PULSE(dn), .INKL(inkl), .GOJAM(gojam),
    .PINC(pinc0), .MINC(minc0), .PCDU(pcdu0), .MCDU(mcdu0),
    .BACKLOG(bl0), .OVF(ovf0), .STALL(stall0)
`ifdef COUNTER_PULSE_SOURCE_COUNT_EN
    , .SERVICED(srv0)
`endif
  );

  counter_pulse_source #(.ACC_W(ACC_W), .CDU_MODE(1), .TIMEOUT(TIMEOUT)) dut1 (
    .CLOCK(CLOCK), .rst(rst), .UP_PULSE(up), .DN_PULSE(dn), .INKL(inkl), .GOJAM(gojam),
    .PINC(pinc1), .MINC(minc1), .PCDU(pcdu1), .MCDU(mcdu1),
    .BACKLOG(bl1), .OVF(ovf1), .STALL(stall1)
`ifdef COUNTER_PULSE_SOURCE_COUNT_EN
    , .SERVICED(srv1)
`endif
  );

  typedef struct {
    bit plus;
    bit minus;
    int backlog;
    bit ovf;
    bit stall;
    int serviced;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: one outstanding increment with a direction, a service flag and a wait age.
  int m_backlog, m_dir, m_age, m_serviced;
  bit m_in_service, m_gap, m_ovf, m_stall;

  function automatic void check(string name, int act, int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  function automatic void compare_all(exp_t e);
    check("pinc",       int'(pinc0), int'(e.plus));
    check("minc",       int'(minc0), int'(e.minus));
    check("pcdu_off",   int'(pcdu0 | mcdu0), 0);
    check("pcdu",       int'(pcdu1), int'(e.plus));
    check("mcdu",       int'(mcdu1), int'(e.minus));
    check("pinc_off",   int'(pinc1 | minc1), 0);
    check("backlog",    int'($signed(bl0)), e.backlog);
    check("backlog_cdu", int'($signed(bl1)), e.backlog);
    check("ovf",        int'(ovf0), int'(e.ovf));
    check("stall",      int'(stall0), int'(e.stall));
    check("stall_cdu",  int'(stall1), int'(e.stall));
`ifdef COUNTER_PULSE_SOURCE_COUNT_EN
    check("serviced",   int'(srv0), e.serviced);
    check("serviced_cdu", int'(srv1), e.serviced);
`endif
  endfunction

  function automatic void model_reset();
    m_backlog = 0; m_dir = 0; m_age = 0; m_serviced = 0;
    m_in_service = 0; m_gap = 0; m_ovf = 0; m_stall = 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.plus     = (m_dir == 1);
    e.minus    = (m_dir == -1);
    e.backlog  = m_backlog;
    e.ovf      = m_ovf;
    e.stall    = m_stall;
    e.serviced = m_serviced;
    return e;
  endfunction

  function automatic void model_step(bit u, bit d, bit k, bit g);
    bit complete;
    int nb;
    complete = !g && (m_dir != 0) && m_in_service && !k;
    nb = m_backlog + int'(u) - int'(d) - (complete ? m_dir : 0);
    if (nb > BMAX) begin nb = BMAX; m_ovf = 1; end
    if (nb < BMIN) begin nb = BMIN; m_ovf = 1; end
    if (g) begin
      m_dir = 0; m_in_service = 0; m_gap = 0; m_age = 0;
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_dir == 0) begin
      if (m_backlog != 0) begin
        m_dir = (m_backlog > 0) ? 1 : -1;
        m_age = 0;
      end
    end else if (!m_in_service) begin
      if (k) begin
        m_in_service = 1; m_age = 0;
      end else if (m_age == TIMEOUT - 1) begin
        m_stall = 1;
      end else begin
        m_age++;
      end
    end else if (complete) begin
      m_dir = 0; m_in_service = 0; m_gap = 1;
      m_serviced = (m_serviced + 1) % 65536;
    end
    m_backlog = nb;
  endfunction

  task automatic step(input bit u, input bit d, input bit k, input bit g);
    rst = 1'b0; up = u; dn = d; inkl = k; gojam = g;
    model_step(u, d, k, g);
    @(posedge CLOCK);
    #1;
    q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic service();
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
  endtask

  // Asserted between edges; outputs must clear without a clock.
  task automatic async_reset_check();
    #5;
    rst = 1'b1;
    model_reset();
    #2;
    compare_all(model_out());
  endtask

  initial begin
    forever begin
      @(negedge CLOCK);
      if (q.size() > 0) compare_all(q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; up = 1'b0; dn = 1'b0; inkl = 1'b0; gojam = 1'b0;
    model_reset();
    @(posedge CLOCK);
    #1;
    q.push_back(model_out());

    // three ups, serviced one at a time
    repeat (3) step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      idle(2);
      service();
    end
    idle(3);

    // cancelling pulses, then two downs
    repeat (5) step(1, 1, 0, 0);
    repeat (2) step(0, 1, 0, 0);
    idle(3);
    for (int i = 0; i < 2; i++) begin
      service();
      idle(2);
    end

    // timeout: request held without INKL
    step(1, 0, 0, 0);
    idle(70);
    service();
    idle(3);

    // saturation, then reset in the middle of service
    repeat (130) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    async_reset_check();
    idle(2);

    // GOJAM while in service with a backlog of 4
    repeat (4) step(1, 0, 0, 0);
    idle(2);
    step(0, 0, 1, 0);
    step(1, 0, 1, 1);
    step(0, 0, 0, 0);
    idle(3);
    service();
    idle(2);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0, ($urandom % 60) == 0);
    end
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 2) == 0, ($urandom % 8) == 0, ($urandom % 7) == 0, 1'b0);
    end
    idle(2);

    repeat (2) @(negedge CLOCK);
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
